// File: rtl/branch_pkg.sv
// Shared definitions for the B-form branch unit: body field layout,
// unit identity and the stage A state encoding.
package branch_pkg;

    // Body layout, MSB-0 order: BO[0:4] BI[5:9] BD16[10:25] AA[26] LK[27]
    localparam int BODY_W         = 28;
    localparam int BO_LSB         = 23;
    localparam int BI_LSB         = 18;
    localparam int BD_LSB         = 2;
    localparam int AA_BIT         = 1;
    localparam int LK_BIT         = 0;

    localparam int BC_OPCODE      = 25;
    localparam int BRANCH_UNIT_ID = 6;

    typedef enum logic [1:0] {
        A_IDLE,
        A_WAIT_CR,
        A_EVAL
    } stage_a_e;

    function automatic logic [63:0] mode_mask(
        input logic [63:0] v,
        input logic        is64
    );
        return is64 ? v : {32'd0, v[31:0]};
    endfunction

endpackage

// File: rtl/bc_condition_eval.sv
// BO/BI condition evaluation for bc: CTR decrement/test and CR bit test.
// BO is held as a [4:0] vector, so BO[k] (MSB-0) lives at bo_i[4-k].
module bc_condition_eval (
    input  logic [4:0]  bo_i,
    input  logic [4:0]  bi_i,
    input  logic [63:0] ctr_i,
    input  logic [31:0] cr_i,
    input  logic        is64Bit_i,
    output logic [63:0] ctrM_o,
    output logic        ctrOk_o,
    output logic        condOk_o,
    output logic        taken_o
);

    logic ctrZero;

    assign ctrM_o   = bo_i[2] ? ctr_i : ctr_i - 64'd1;
    assign ctrZero  = is64Bit_i ? (ctrM_o == 64'd0)
                                : (ctrM_o[31:0] == 32'd0);
    assign ctrOk_o  = bo_i[2] | (ctrZero ^ ~bo_i[1]);
    // CR bit BI in MSB-0 numbering
    assign condOk_o = bo_i[4] | (cr_i[5'd31 - bi_i] == bo_i[3]);
    assign taken_o  = ctrOk_o & condOk_o;

endmodule

// File: rtl/bform_branch_unit.sv
// bc execution unit: owns CTR/LR, resolves the next fetch address
// through an evaluate stage (A) and a result stage (B).
module bform_branch_unit
    import branch_pkg::*;
#(
    parameter int addressWidth            = 64,
    parameter int instructionCounterWidth = 64,
    parameter int opcodeSize              = 12,
    parameter int bodySize                = BODY_W,
    parameter int bcOpcode                = BC_OPCODE
) (
    input  logic                               clock_i,
    input  logic                               reset_i,
    input  logic                               enable_i,
    output logic                               ready_o,
    input  logic [opcodeSize-1:0]              opcode_i,
    input  logic [addressWidth-1:0]            instructionAddress_i,
    input  logic [instructionCounterWidth-1:0] instMajId_i,
    input  logic                               is64Bit_i,
    input  logic [bodySize-1:0]                instructionBody_i,
    input  logic [31:0]                        cr_i,
    input  logic                               crBusy_i,
    input  logic                               ctrWrite_i,
    input  logic                               lrWrite_i,
    input  logic [63:0]                        sprData_i,
    input  logic                               flush_i,
    input  logic                               stall_i,
    output logic                               valid_o,
    output logic                               taken_o,
    output logic [addressWidth-1:0]            nextAddress_o,
    output logic [instructionCounterWidth-1:0] majId_o,
    output logic [63:0]                        ctr_o,
    output logic [63:0]                        lr_o
);

    logic                               aValid_q, aValid_d;
    logic [addressWidth-1:0]            aCia_q, aCia_d;
    logic [instructionCounterWidth-1:0] aMajId_q, aMajId_d;
    logic                               aIs64_q, aIs64_d;
    logic [bodySize-1:0]                aBody_q, aBody_d;

    logic                               bValid_q, bValid_d;
    logic                               bTaken_q, bTaken_d;
    logic [addressWidth-1:0]            bNext_q, bNext_d;
    logic [instructionCounterWidth-1:0] bMajId_q, bMajId_d;

    logic [63:0] ctr_q, ctr_d;
    logic [63:0] lr_q, lr_d;

    stage_a_e    aState;
    logic        advance;
    logic        accept;
    logic        isBc;
    logic [4:0]  bo;
    logic [15:0] bd;
    logic [63:0] cia64;
    logic [63:0] target;
    logic [63:0] fallthrough;
    logic [63:0] evalCtrM;
    logic        evalCtrOk;
    logic        evalCondOk;
    logic        evalTaken;
    logic        unusedEval;

    assign bo    = aBody_q[BO_LSB +: 5];
    assign bd    = aBody_q[BD_LSB +: 16];
    assign cia64 = 64'(aCia_q);

    bc_condition_eval u_eval (
        .bo_i      (bo),
        .bi_i      (aBody_q[BI_LSB +: 5]),
        .ctr_i     (ctr_q),
        .cr_i      (cr_i),
        .is64Bit_i (aIs64_q),
        .ctrM_o    (evalCtrM),
        .ctrOk_o   (evalCtrOk),
        .condOk_o  (evalCondOk),
        .taken_o   (evalTaken)
    );

    assign unusedEval = evalCtrOk ^ evalCondOk;

    assign target = mode_mask(
        (aBody_q[AA_BIT] ? 64'd0 : cia64) + {{48{bd[15]}}, bd},
        aIs64_q);
    assign fallthrough = mode_mask(cia64 + 64'd4, aIs64_q);

    always_comb begin
        aState = A_IDLE;
        if (aValid_q) begin
            aState = (!bo[4] && crBusy_i) ? A_WAIT_CR : A_EVAL;
        end
    end

    assign advance = (aState == A_EVAL) && !flush_i
                     && (!bValid_q || !stall_i);
    assign ready_o = !aValid_q || advance;
    assign accept  = enable_i && ready_o && !flush_i;
    assign isBc    = (opcode_i == opcodeSize'(bcOpcode));

    always_comb begin
        aValid_d = aValid_q;
        aCia_d   = aCia_q;
        aMajId_d = aMajId_q;
        aIs64_d  = aIs64_q;
        aBody_d  = aBody_q;
        if (advance) begin
            aValid_d = 1'b0;
        end
        if (accept) begin
            aValid_d = isBc;
            if (isBc) begin
                aCia_d   = instructionAddress_i;
                aMajId_d = instMajId_i;
                aIs64_d  = is64Bit_i;
                aBody_d  = instructionBody_i;
            end
        end
        if (flush_i) begin
            aValid_d = 1'b0;
        end
    end

    always_comb begin
        bValid_d = bValid_q;
        bTaken_d = bTaken_q;
        bNext_d  = bNext_q;
        bMajId_d = bMajId_q;
        if (bValid_q && !stall_i) begin
            bValid_d = 1'b0;
        end
        if (advance) begin
            bValid_d = 1'b1;
            bTaken_d = evalTaken;
            bNext_d  = addressWidth'(evalTaken ? target : fallthrough);
            bMajId_d = aMajId_q;
        end
        if (flush_i) begin
            bValid_d = 1'b0;
        end
    end

    // A retiring branch overrides a same-cycle mtspr to the same register
    always_comb begin
        ctr_d = ctr_q;
        lr_d  = lr_q;
        if (ctrWrite_i) begin
            ctr_d = sprData_i;
        end
        if (lrWrite_i) begin
            lr_d = sprData_i;
        end
        if (advance && !bo[2]) begin
            ctr_d = evalCtrM;
        end
        if (advance && aBody_q[LK_BIT]) begin
            lr_d = fallthrough;
        end
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            aValid_q <= 1'b0;
            aCia_q   <= '0;
            aMajId_q <= '0;
            aIs64_q  <= 1'b0;
            aBody_q  <= '0;
            bValid_q <= 1'b0;
            bTaken_q <= 1'b0;
            bNext_q  <= '0;
            bMajId_q <= '0;
            ctr_q    <= '0;
            lr_q     <= '0;
        end else begin
            aValid_q <= aValid_d;
            aCia_q   <= aCia_d;
            aMajId_q <= aMajId_d;
            aIs64_q  <= aIs64_d;
            aBody_q  <= aBody_d;
            bValid_q <= bValid_d;
            bTaken_q <= bTaken_d;
            bNext_q  <= bNext_d;
            bMajId_q <= bMajId_d;
            ctr_q    <= ctr_d;
            lr_q     <= lr_d;
        end
    end

    assign valid_o       = bValid_q;
    assign taken_o       = bTaken_q;
    assign nextAddress_o = bNext_q;
    assign majId_o       = bMajId_q;
    assign ctr_o         = ctr_q;
    assign lr_o          = lr_q;

endmodule

// File: tb/tb_bform_branch_unit.sv
// Scoreboard bench for bform_branch_unit: directed scenarios plus a
// randomized phase, checked against a behavioural bc model.
module tb_bform_branch_unit;

    logic        clock_i = 1'b0;
    logic        reset_i = 1'b0;
    logic        enable_i = 1'b0;
    logic        ready_o;
    logic [11:0] opcode_i = '0;
    logic [63:0] instructionAddress_i = '0;
    logic [63:0] instMajId_i = '0;
    logic        is64Bit_i = 1'b0;
    logic [27:0] instructionBody_i = '0;
    logic [31:0] cr_i = '0;
    logic        crBusy_i = 1'b0;
    logic        ctrWrite_i = 1'b0;
    logic        lrWrite_i = 1'b0;
    logic [63:0] sprData_i = '0;
    logic        flush_i = 1'b0;
    logic        stall_i = 1'b0;
    logic        valid_o;
    logic        taken_o;
    logic [63:0] nextAddress_o;
    logic [63:0] majId_o;
    logic [63:0] ctr_o;
    logic [63:0] lr_o;

    bform_branch_unit dut (
        .clock_i              (clock_i),
        .reset_i              (reset_i),
        .enable_i             (enable_i),
        .ready_o              (ready_o),
        .opcode_i             (opcode_i),
        .instructionAddress_i (instructionAddress_i),
        .instMajId_i          (instMajId_i),
        .is64Bit_i            (is64Bit_i),
        .instructionBody_i    (instructionBody_i),
        .cr_i                 (cr_i),
        .crBusy_i             (crBusy_i),
        .ctrWrite_i           (ctrWrite_i),
        .lrWrite_i            (lrWrite_i),
        .sprData_i            (sprData_i),
        .flush_i              (flush_i),
        .stall_i              (stall_i),
        .valid_o              (valid_o),
        .taken_o              (taken_o),
        .nextAddress_o        (nextAddress_o),
        .majId_o              (majId_o),
        .ctr_o                (ctr_o),
        .lr_o                 (lr_o)
    );

    always #5 clock_i = ~clock_i;

    typedef struct {
        logic        taken;
        logic [63:0] next;
        logic [63:0] majId;
        logic [63:0] ctr;
        logic [63:0] lr;
    } exp_t;

    exp_t        sbq[$];
    int          resCycles[$];
    int          nChecks = 0;
    int          nFails = 0;
    int          cycle = 0;
    bit          rndOn = 1'b0;
    logic [63:0] mCtr = '0;
    logic [63:0] mLr = '0;

    always @(posedge clock_i) cycle++;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Architectural bc semantics; BO[k] in MSB-0 is bo[4-k].
    function automatic exp_t model(
        input logic [4:0] bo, input logic [4:0] bi, input logic [15:0] bd,
        input logic aa, input logic lk, input logic is64,
        input logic [63:0] cia, input logic [63:0] mid);
        exp_t        e;
        logic [63:0] c, tgt, ft;
        bit          zero, ctrGood, condGood, crBit;
        bit          noCtr, wantZero, noCond, wantBit;
        noCond   = bo[4];
        wantBit  = bo[3];
        noCtr    = bo[2];
        wantZero = bo[1];
        c = mCtr;
        if (!noCtr) c = c - 64'd1;
        zero = is64 ? (c == 64'd0) : (c[31:0] == 32'd0);
        if (noCtr) ctrGood = 1'b1;
        else if (wantZero) ctrGood = zero;
        else ctrGood = !zero;
        crBit    = cr_i[31 - int'(bi)];
        condGood = noCond ? 1'b1 : (crBit == wantBit);
        tgt = (aa ? 64'd0 : cia) + 64'(longint'(shortint'(bd)));
        ft  = cia + 64'd4;
        if (!is64) begin
            tgt = tgt & 64'h0000_0000_FFFF_FFFF;
            ft  = ft & 64'h0000_0000_FFFF_FFFF;
        end
        mCtr = c;
        if (lk) mLr = ft;
        e.taken = ctrGood && condGood;
        e.next  = e.taken ? tgt : ft;
        e.majId = mid;
        e.ctr   = mCtr;
        e.lr    = mLr;
        return e;
    endfunction

    always @(negedge clock_i) begin
        exp_t e;
        if (reset_i && valid_o && !stall_i) begin
            if (sbq.size() == 0) begin
                nChecks++;
                nFails++;
                $display("FAIL unexpected_result: got nextAddress 0x%0h, expected none",
                         nextAddress_o);
            end else begin
                e = sbq.pop_front();
                chk("res_taken", 64'(taken_o), 64'(e.taken));
                chk("res_next", nextAddress_o, e.next);
                chk("res_majId", majId_o, e.majId);
                chk("res_ctr", ctr_o, e.ctr);
                chk("res_lr", lr_o, e.lr);
                resCycles.push_back(cycle);
            end
        end
    end

    task automatic randomizeCtl();
        if (rndOn) begin
            stall_i  = ($urandom_range(0, 3) == 0);
            crBusy_i = ($urandom_range(0, 3) == 0);
        end
    endtask

    task automatic idle(input int k);
        repeat (k) begin
            @(posedge clock_i);
            #1;
            randomizeCtl();
        end
    endtask

    task automatic send(
        input logic [11:0] opc, input logic [4:0] bo, input logic [4:0] bi,
        input logic [15:0] bd, input logic aa, input logic lk,
        input logic is64, input logic [63:0] cia, input logic [63:0] mid,
        input bit track);
        int   n;
        logic rdy;
        n = 0;
        opcode_i             = opc;
        instructionAddress_i = cia;
        instMajId_i          = mid;
        is64Bit_i            = is64;
        instructionBody_i    = {bo, bi, bd, aa, lk};
        enable_i             = 1'b1;
        do begin
            @(negedge clock_i);
            rdy = ready_o && !flush_i;
            if (rdy && track && opc == 12'd25)
                sbq.push_back(model(bo, bi, bd, aa, lk, is64, cia, mid));
            @(posedge clock_i);
            #1;
            n++;
            randomizeCtl();
        end while (!rdy && n < 200);
        enable_i = 1'b0;
        if (!rdy) chk("accept_timeout", 64'(n), 64'd0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 400) begin
            idle(1);
            n++;
        end
        chk("drain_empty", 64'(sbq.size()), 64'd0);
        idle(2);
    endtask

    task automatic writeCtr(input logic [63:0] v);
        ctrWrite_i = 1'b1;
        sprData_i  = v;
        @(posedge clock_i);
        #1;
        ctrWrite_i = 1'b0;
        mCtr = v;
    endtask

    task automatic chkIdle(input string tag);
        chk({tag, "_valid"}, 64'(valid_o), 64'd0);
        chk({tag, "_taken"}, 64'(taken_o), 64'd0);
        chk({tag, "_next"}, nextAddress_o, 64'd0);
        chk({tag, "_majId"}, majId_o, 64'd0);
        chk({tag, "_ctr"}, ctr_o, 64'd0);
        chk({tag, "_lr"}, lr_o, 64'd0);
        chk({tag, "_ready"}, 64'(ready_o), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] lrPrev, ctrPrev;
        int          nRes, relCycle;
        logic [11:0] opc;

        repeat (2) @(posedge clock_i);
        #1;
        chkIdle("reset");
        reset_i = 1'b1;
        idle(1);

        // bdnz loop, CTR=3, three back-to-back
        writeCtr(64'd3);
        chk("ctr_load", ctr_o, 64'd3);
        resCycles.delete();
        for (int i = 0; i < 3; i++)
            send(12'd25, 5'b10000, 5'd0, 16'hFFF8, 1'b0, 1'b0, 1'b1,
                 64'h1000, 64'(i + 1), 1'b1);
        drain();
        chk("bdnz_count", 64'(resCycles.size()), 64'd3);
        if (resCycles.size() >= 3) begin
            chk("bdnz_gap1", 64'(resCycles[1] - resCycles[0]), 64'd1);
            chk("bdnz_gap2", 64'(resCycles[2] - resCycles[1]), 64'd1);
        end
        chk("bdnz_ctr", ctr_o, 64'd0);

        // absolute taken branch with link
        cr_i = 32'h2000_0000;
        send(12'd25, 5'b01100, 5'd2, 16'h0040, 1'b1, 1'b1, 1'b1,
             64'h2000, 64'd10, 1'b1);
        drain();
        chk("link_lr", lr_o, 64'h2004);
        chk("link_ctr", ctr_o, 64'd0);

        // CR busy for three cycles
        lrPrev   = mLr;
        crBusy_i = 1'b1;
        send(12'd25, 5'b00100, 5'd2, 16'h0010, 1'b0, 1'b1, 1'b1,
             64'h3000, 64'd11, 1'b1);
        repeat (3) begin
            @(negedge clock_i);
            chk("crwait_ready", 64'(ready_o), 64'd0);
            chk("crwait_valid", 64'(valid_o), 64'd0);
            chk("crwait_lr", lr_o, lrPrev);
            @(posedge clock_i);
            #1;
        end
        crBusy_i = 1'b0;
        relCycle = cycle;
        drain();
        if (resCycles.size() > 0)
            chk("crwait_latency", 64'(resCycles[$] - relCycle), 64'd1);

        // stall with two packets in flight
        nRes    = resCycles.size();
        stall_i = 1'b1;
        send(12'd25, 5'b10000, 5'd0, 16'h0020, 1'b0, 1'b0, 1'b1,
             64'h5000, 64'd12, 1'b1);
        send(12'd25, 5'b10000, 5'd0, 16'h0030, 1'b0, 1'b1, 1'b1,
             64'h6000, 64'd13, 1'b1);
        repeat (2) begin
            @(negedge clock_i);
            chk("stall_ready", 64'(ready_o), 64'd0);
            chk("stall_valid", 64'(valid_o), 64'd1);
            if (sbq.size() > 0) begin
                chk("stall_next", nextAddress_o, sbq[0].next);
                chk("stall_majId", majId_o, sbq[0].majId);
            end
            @(posedge clock_i);
            #1;
        end
        stall_i = 1'b0;
        drain();
        chk("stall_count", 64'(resCycles.size() - nRes), 64'd2);

        // flush a packet sitting in stage A
        ctrPrev = mCtr;
        send(12'd25, 5'b10000, 5'd0, 16'h0008, 1'b0, 1'b1, 1'b1,
             64'h7000, 64'd14, 1'b0);
        flush_i = 1'b1;
        @(posedge clock_i);
        #1;
        flush_i = 1'b0;
        idle(4);
        chk("flush_valid", 64'(valid_o), 64'd0);
        chk("flush_ctr", ctr_o, ctrPrev);

        // 32-bit mode: low word of decremented CTR is zero
        writeCtr(64'h1_0000_0001);
        send(12'd25, 5'b10000, 5'd0, 16'h0100, 1'b0, 1'b0, 1'b0,
             64'h4000, 64'd20, 1'b1);
        drain();
        chk("m32_ctr", ctr_o, 64'h1_0000_0000);

        // 32-bit fallthrough wraps to zero
        cr_i = 32'h0;
        send(12'd25, 5'b01100, 5'd0, 16'h0000, 1'b0, 1'b1, 1'b0,
             64'hFFFF_FFFC, 64'd21, 1'b1);
        drain();
        chk("m32_lr", lr_o, 64'd0);

        // mtspr CTR colliding with a bdnz advance
        writeCtr(64'd5);
        send(12'd25, 5'b10000, 5'd0, 16'h0004, 1'b0, 1'b0, 1'b1,
             64'h8000, 64'd22, 1'b1);
        ctrWrite_i = 1'b1;
        sprData_i  = 64'hDEAD;
        @(posedge clock_i);
        #1;
        ctrWrite_i = 1'b0;
        drain();
        chk("collide_ctr", ctr_o, 64'd4);

        // non-bc opcode is dropped
        send(12'd7, 5'b10000, 5'd0, 16'h0004, 1'b0, 1'b1, 1'b1,
             64'h9000, 64'd23, 1'b1);
        idle(4);
        chk("nonbc_ctr", ctr_o, 64'd4);
        chk("nonbc_valid", 64'(valid_o), 64'd0);

        // randomized traffic with random stall / CR busy
        writeCtr(64'd6);
        cr_i  = $urandom;
        rndOn = 1'b1;
        for (int i = 0; i < 300; i++) begin
            opc = ($urandom_range(0, 7) == 0) ? 12'd99 : 12'd25;
            send(opc, 5'($urandom), 5'($urandom), 16'($urandom),
                 1'($urandom), 1'($urandom), 1'($urandom),
                 {32'($urandom), 32'($urandom)} & ~64'd3,
                 64'(i + 100), 1'b1);
            idle($urandom_range(0, 2));
        end
        rndOn    = 1'b0;
        stall_i  = 1'b0;
        crBusy_i = 1'b0;
        drain();

        // asynchronous reset with both stages occupied
        stall_i = 1'b1;
        send(12'd25, 5'b10000, 5'd0, 16'h0040, 1'b0, 1'b1, 1'b1,
             64'hA000, 64'd500, 1'b0);
        send(12'd25, 5'b10000, 5'd0, 16'h0040, 1'b0, 1'b1, 1'b1,
             64'hB000, 64'd501, 1'b0);
        chk("prereset_valid", 64'(valid_o), 64'd1);
        #2;
        reset_i = 1'b0;
        #1;
        chkIdle("async_reset");
        stall_i = 1'b0;
        @(posedge clock_i);
        #1;
        reset_i = 1'b1;
        mCtr = '0;
        mLr  = '0;
        sbq.delete();
        idle(3);
        chk("postreset_valid", 64'(valid_o), 64'd0);
        chk("postreset_ctr", ctr_o, 64'd0);

        chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 nChecks, nFails);
        $finish;
    end

endmodule
